// File: rtl/seg7_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_pkg
// Brief    : Hex-to-abcdefg table and polarity helpers for the digit scanner.
// Revision : 1.0
// ============================================================================
package seg7_scan_pkg;

    // Segment order abcdefg, a = MSB; entry 15 first in the packed list.
    localparam logic [15:0][6:0] c_hex7_table = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    localparam logic [6:0] c_seg_blank   = 7'h00;
    localparam bit         c_active_high = 1'b0;
    localparam bit         c_active_low  = 1'b1;

    function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input bit active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage : seg7_scan_pkg
`default_nettype wire

// File: rtl/seg7_scan_hex7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex7seg
// Brief    : Combinational nibble to abcdefg decoder.
// Revision : 1.0
// ============================================================================
module hex7seg
    import seg7_scan_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = c_hex7_table[i_nibble];

endmodule : hex7seg
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan
// Brief    : Time-multiplexed 7-segment scanner with tear-free update,
//            anti-ghosting gap, leading-zero blanking and frame strobe.
// Revision : 1.0
// ============================================================================
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int NDIG           = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int GAP            = 16,
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = c_active_high,
    parameter bit DIG_ACTIVE_LOW = c_active_high
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [4*NDIG-1:0]   VALUE,
    input  logic [NDIG-1:0]     DP,
    input  logic                LOAD,
    input  logic                BLANK,
    output logic [6:0]          SEG,
    output logic                SEG_DP,
    output logic [NDIG-1:0]     DIG,
    output logic                FRAME
);

    localparam int              c_pw      = $clog2(SCAN_DIV);
    localparam int              c_iw      = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [c_pw-1:0] c_p_last  = c_pw'(SCAN_DIV - 1);
    localparam logic [c_iw-1:0] c_i_last  = c_iw'(NDIG - 1);
    localparam logic [c_pw-1:0] c_gap     = c_pw'(GAP);
    localparam logic [6:0]      c_seg_off = seg_polarity(c_seg_blank, SEG_ACTIVE_LOW);
    localparam logic            c_dp_off  = SEG_ACTIVE_LOW;
    localparam logic [NDIG-1:0] c_dig_off = {NDIG{DIG_ACTIVE_LOW}};

    logic [c_pw-1:0]   p_q, p_d;
    logic [c_iw-1:0]   idx_q, idx_d;
    logic [4*NDIG-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
    logic [NDIG-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [6:0]        seg_q, seg_d;
    logic              seg_dp_q, seg_dp_d;
    logic [NDIG-1:0]   dig_q, dig_d;
    logic              frame_q, frame_d;

    logic              w_p_wrap;
    logic              w_frame_start;
    logic              w_seen;
    logic [NDIG-1:0]   w_lz;
    logic [NDIG-1:0]   w_onehot;
    logic [3:0]        w_nibble;
    logic [6:0]        w_seg_raw;
    logic              w_active;

    assign w_nibble = disp_val_q[{idx_q, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_raw)
    );

    always_comb begin
        w_p_wrap      = (p_q == c_p_last);
        w_frame_start = w_p_wrap && (idx_q == c_i_last);

        p_d   = w_p_wrap ? '0 : p_q + c_pw'(1);
        idx_d = idx_q;
        if (w_p_wrap) begin
            idx_d = (idx_q == c_i_last) ? '0 : idx_q + c_iw'(1);
        end

        pend_val_d = LOAD ? VALUE : pend_val_q;
        pend_dp_d  = LOAD ? DP    : pend_dp_q;
        // Taking pend_*_d lets a LOAD on the frame-start cycle land in this frame.
        disp_val_d = w_frame_start ? pend_val_d : disp_val_q;
        disp_dp_d  = w_frame_start ? pend_dp_d  : disp_dp_q;

        // Scan from the top digit down: a digit is a leading zero until a
        // non-zero nibble or a set DP has been seen at or above it.
        w_seen = 1'b0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            w_seen  = w_seen | (disp_val_q[4*k +: 4] != 4'h0) | disp_dp_q[k];
            w_lz[k] = (k != 0) && !w_seen;
        end

        for (int k = 0; k < NDIG; k++) begin
            w_onehot[k] = (idx_q == c_iw'(k));
        end

        w_active = (p_q >= c_gap) && !BLANK && !(BLANK_LZ && w_lz[idx_q]);

        seg_d    = seg_polarity(w_active ? w_seg_raw : c_seg_blank, SEG_ACTIVE_LOW);
        seg_dp_d = (w_active & disp_dp_q[idx_q]) ^ SEG_ACTIVE_LOW;
        dig_d    = (w_active ? w_onehot : '0) ^ c_dig_off;
        frame_d  = (p_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            p_q        <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            seg_q      <= c_seg_off;
            seg_dp_q   <= c_dp_off;
            dig_q      <= c_dig_off;
            frame_q    <= 1'b0;
        end else begin
            p_q        <= p_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            seg_q      <= seg_d;
            seg_dp_q   <= seg_dp_d;
            dig_q      <= dig_d;
            frame_q    <= frame_d;
        end
    end

    assign SEG    = seg_q;
    assign SEG_DP = seg_dp_q;
    assign DIG    = dig_q;
    assign FRAME  = frame_q;

endmodule : seg7_scan
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seg7_scan
// Brief    : Self-checking bench for seg7_scan (active-high and active-low).
// Revision : 1.0
// ============================================================================
module tb_seg7_scan;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        blank;

    logic [6:0]  seg, seg_n;
    logic        seg_dp, seg_dp_n;
    logic [3:0]  dig, dig_n;
    logic        frame, frame_n;

    always #5 clk = ~clk;

    seg7_scan #(
        .NDIG(4), .SCAN_DIV(8), .GAP(GAP), .BLANK_LZ(1'b1),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) u_dut (
        .CLK(clk), .RST(rst), .VALUE(value), .DP(dp), .LOAD(load), .BLANK(blank),
        .SEG(seg), .SEG_DP(seg_dp), .DIG(dig), .FRAME(frame)
    );

    seg7_scan #(
        .NDIG(4), .SCAN_DIV(8), .GAP(GAP), .BLANK_LZ(1'b1),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) u_dut_n (
        .CLK(clk), .RST(rst), .VALUE(value), .DP(dp), .LOAD(load), .BLANK(blank),
        .SEG(seg_n), .SEG_DP(seg_dp_n), .DIG(dig_n), .FRAME(frame_n)
    );

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic [3:0]      on;
        logic [3:0][6:0] seg;
    } vec_t;

    slot_t sb_q[$];
    vec_t  vecs[7];
    int    total = 0;
    int    bad   = 0;

    function automatic vec_t mk(input logic [15:0] v, input logic [3:0] d, input logic [3:0] on,
                                input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0);
        vec_t r;
        r.value = v;
        r.dp    = d;
        r.on    = on;
        r.seg   = {s3, s2, s1, s0};
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic f, input logic [3:0] d,
                             input logic [6:0] s, input logic p, input logic ef,
                             input logic [3:0] ed, input logic [6:0] es, input logic ep);
        total++;
        if ({f, d, s, p} !== {ef, ed, es, ep}) begin
            bad++;
            $display("FAIL %s: got frame=%b dig=%b seg=%b dp=%b, expected frame=%b dig=%b seg=%b dp=%b",
                     name, f, d, s, p, ef, ed, es, ep);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic push_vec(input vec_t v);
        for (int k = 0; k < 4; k++) begin
            slot_t s;
            s.dig = v.on[k] ? (4'b0001 << k) : 4'b0000;
            s.seg = v.on[k] ? v.seg[k] : 7'h00;
            s.dp  = v.on[k] & v.dp[k];
            sb_q.push_back(s);
        end
    endtask

    task automatic load_vec(input vec_t v);
        value = v.value;
        dp    = v.dp;
        load  = 1'b1;
        push_vec(v);
        step();
        load  = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!frame && n < 100);
        total++;
        if (!frame) begin
            bad++;
            $display("FAIL %s: frame timeout, got frame=%b after %0d cycles, expected 1", name, frame, n);
        end
    endtask

    // Checks one whole frame from its FRAME cycle; optionally loads ld_vec
    // mid-slot of ld_slot, pushing its expectation for the following frame.
    task automatic check_frame(input string name, input int ld_slot, input vec_t ld_vec);
        for (int s = 0; s < 4; s++) begin
            slot_t e;
            e = '0;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL %s: scoreboard empty at slot %0d, got 0 entries, expected 1", name, s);
            end else begin
                e = sb_q.pop_front();
            end
            for (int c = 0; c < 8; c++) begin
                logic       ef;
                logic [3:0] ed;
                logic [6:0] es;
                logic       ep;
                ef = (s == 0) && (c == 0);
                ed = (c >= GAP) ? e.dig : 4'b0000;
                es = (c >= GAP) ? e.seg : 7'h00;
                ep = (c >= GAP) ? e.dp  : 1'b0;
                check_out($sformatf("%s s%0d c%0d", name, s, c), frame, dig, seg, seg_dp, ef, ed, es, ep);
                check_out($sformatf("%s low s%0d c%0d", name, s, c), frame_n, dig_n, seg_n, seg_dp_n,
                          ef, ~ed, ~es, ~ep);
                if (s == ld_slot && c == 3) begin
                    value = ld_vec.value;
                    dp    = ld_vec.dp;
                    load  = 1'b1;
                    push_vec(ld_vec);
                end
                step();
                load = 1'b0;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        vec_t v1111, v3333, v8888;

        vecs[0] = mk(16'h12AF, 4'b0000, 4'b1111, 7'h30, 7'h6D, 7'h77, 7'h47);
        vecs[1] = mk(16'h0007, 4'b0000, 4'b0001, 7'h00, 7'h00, 7'h00, 7'h70);
        vecs[2] = mk(16'h0000, 4'b0000, 4'b0001, 7'h00, 7'h00, 7'h00, 7'h7E);
        vecs[3] = mk(16'h0000, 4'b0100, 4'b0111, 7'h00, 7'h7E, 7'h7E, 7'h7E);
        vecs[4] = mk(16'h0050, 4'b0000, 4'b0011, 7'h00, 7'h00, 7'h5B, 7'h7E);
        vecs[5] = mk(16'h8888, 4'b1010, 4'b1111, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        vecs[6] = mk(16'h0E00, 4'b0001, 4'b0111, 7'h00, 7'h4F, 7'h7E, 7'h7E);
        v1111   = mk(16'h1111, 4'b0000, 4'b1111, 7'h30, 7'h30, 7'h30, 7'h30);
        v3333   = mk(16'h3333, 4'b0000, 4'b1111, 7'h79, 7'h79, 7'h79, 7'h79);
        v8888   = mk(16'h8888, 4'b0000, 4'b1111, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        rst = 1'b1; value = '0; dp = '0; load = 1'b0; blank = 1'b0;

        for (int c = 0; c < 3; c++) begin
            step();
            check_out($sformatf("reset c%0d", c), frame, dig, seg, seg_dp, 1'b0, 4'b0000, 7'h00, 1'b0);
            check_out($sformatf("reset low c%0d", c), frame_n, dig_n, seg_n, seg_dp_n,
                      1'b0, 4'b1111, 7'h7F, 1'b1);
        end
        rst = 1'b0;

        n = 0;
        do begin
            step();
            n++;
        end while (dig != 4'b0001 && n < 20);
        check_int("first dig0 latency", n, 3);
        check_out("first dig0 seg", frame, dig, seg, seg_dp, 1'b0, 4'b0001, 7'h7E, 1'b0);

        wait_frame("period start");
        n = 0;
        do begin
            step();
            n++;
        end while (!frame && n < 100);
        check_int("frame period", n, 32);

        for (int i = 0; i < 7; i++) begin
            load_vec(vecs[i]);
            wait_frame($sformatf("vec%0d wait", i));
            check_frame($sformatf("vec%0d", i), -1, vecs[0]);
        end

        // Load during slot 1 must not tear the frame currently on display.
        load_vec(v1111);
        wait_frame("tear wait");
        check_frame("tear old", 1, v3333);
        check_frame("tear new", -1, v3333);

        // BLANK mid-slot: off next cycle, frame strobe keeps running.
        repeat (12) step();
        check_out("pre blank", frame, dig, seg, seg_dp, 1'b0, 4'b0010, 7'h79, 1'b0);
        blank = 1'b1;
        step();
        check_out("blank on", frame, dig, seg, seg_dp, 1'b0, 4'b0000, 7'h00, 1'b0);
        n = 0;
        for (int c = 0; c < 32; c++) begin
            step();
            if (frame) n++;
        end
        check_int("frames during blank", n, 1);
        check_out("still blank", frame, dig, seg, seg_dp, 1'b0, 4'b0000, 7'h00, 1'b0);
        blank = 1'b0;
        step();
        check_out("blank release", frame, dig, seg, seg_dp, 1'b0, 4'b0010, 7'h79, 1'b0);

        // Reset in digit 2's slot aborts the frame and clears the value.
        repeat (6) step();
        check_out("pre rst dig2", frame, dig, seg, seg_dp, 1'b0, 4'b0100, 7'h79, 1'b0);
        rst = 1'b1;
        step();
        check_out("mid rst", frame, dig, seg, seg_dp, 1'b0, 4'b0000, 7'h00, 1'b0);
        check_out("mid rst low", frame_n, dig_n, seg_n, seg_dp_n, 1'b0, 4'b1111, 7'h7F, 1'b1);
        rst = 1'b0;
        step();
        check_out("restart frame", frame, dig, seg, seg_dp, 1'b1, 4'b0000, 7'h00, 1'b0);
        step();
        step();
        check_out("restart dig0", frame, dig, seg, seg_dp, 1'b0, 4'b0001, 7'h7E, 1'b0);

        // Active-low instance: lit 8 drives every segment low.
        load_vec(v8888);
        wait_frame("low8 wait");
        check_frame("low8", -1, v8888);
        check_int("scoreboard drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seg7_scan
`default_nettype wire
